control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Next-generation decode/control unit for the pipelined RV32 core.
- Decodes opcode/funct fields in the D stage, including JALR, LUI, AUIPC and, optionally, M-extension ops.
- Registers all control into the D->E pipeline boundary, with stall/flush handling.
- Generates a multi-cycle busy stall for MUL/DIV, and flags illegal instructions.

Parameters:
- ENABLE_M, 1: decode M-extension (OP_R with funct7=0000001); when 0, such encodings are illegal.
- ENABLE_UPPER, 1: decode LUI/AUIPC; when 0, they are illegal.
- MULDIV_CYCLES, 4: cycles an M-op occupies E (>=1); counter width is clog2(MULDIV_CYCLES+1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_d  in  1  D-stage instruction valid
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- stall_e  in  1  external hold of E register (hazard unit)
- flush_e  in  1  insert bubble into E (branch mispredict)
- stall_d  out  1  request fetch/decode hold (muldiv busy)
- illegal_d  out  1  combinational: valid_d and undecodable
- illegal_sticky  out  1  set once an illegal instr enters E
- valid_e  out  1  E-stage valid
- regwrite_e  out  1  register write enable
- memwrite_e  out  1  memory write enable
- jump_e  out  1  JAL or JALR
- jalr_e  out  1  target = rs1+imm
- branch_e  out  1  conditional branch
- alu_src_e  out  1  ALU B = immediate
- alu_a_pc_e  out  1  ALU A = PC (AUIPC)
- muldiv_e  out  1  E holds an M-op
- result_src_e  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- alu_control_e  out  4  ALU operation
- branch_control_e  out  3  funct3 for branches, else 000

Behaviour:
- Decode table, as {regwrite, alu_src, alu_a_pc, memwrite, result_src, branch, jump, jalr}:
  - LW 0000011: 1,1,0,0,01,0,0,0
  - SW 0100011: 0,1,0,1,00,0,0,0
  - R 0110011: 1,0,0,0,00,0,0,0
  - I 0010011: 1,1,0,0,00,0,0,0
  - B 1100011: 0,0,0,0,00,1,0,0
  - JAL 1101111: 1,0,0,0,10,0,1,0
  - JALR 1100111: 1,1,0,0,10,0,1,1
  - LUI 0110111: 1,0,0,0,11,0,0,0
  - AUIPC 0010111: 1,1,1,0,00,0,0,0
- alu_control: from alu_decode; forced to ADD 0000 for LW/SW/JALR/AUIPC/LUI.
- M-op: R-type with funct7=0000001 and ENABLE_M=1. muldiv=1, alu_control = {1, funct3}.
- branch_control: funct3 only for OP_B, else 000.
- Illegal instruction: any other opcode, a disabled option, or R-type funct7 not in {0000000, 0100000, 0000001}.
  - All decoded control forced to 0.
  - illegal_d = valid_d & illegal.
- Reset (async, rst_n=0): all *_e outputs 0, counter 0, illegal_sticky 0, stall_d 0.
- E register update, in priority order each clk edge:
  1. flush_e: bubble (valid_e=0, all control 0), counter cleared.
  2. stall_e: hold all; counter frozen.
  3. counter!=0: hold all; counter decrements.
  4. Otherwise: load decode gated by valid_d. If valid_d=0, load a bubble.
- Muldiv: when an M-op is loaded, counter <= MULDIV_CYCLES-1.
  - stall_d = (counter!=0).
  - An M-op therefore occupies E for exactly MULDIV_CYCLES cycles with no external stall.
  - MULDIV_CYCLES=1 gives no stall.
- illegal_sticky: set on a load with valid_d & illegal; cleared only by reset.
- Load latency: decode visible on *_e 1 cycle after valid_d.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - result_src encodings RES_ALU/RES_MEM/RES_PC4/RES_IMM
  - ALU code ALU_ADD
  - FUNCT7_M
- Sub-module alu_decode (funct3, funct7b5, opcode -> alu_control) is instantiated, not duplicated.

Test Plan:
- Reset mid-operation: assert rst_n=0 while counter=2 -> all outputs 0 immediately (async), stall_d=0.
- LW: opcode=0000011, valid_d=1 -> next cycle valid_e=1, regwrite_e=1, alu_src_e=1, result_src_e=01, alu_control_e=0000.
- JALR then AUIPC on consecutive cycles:
  - JALR -> jump_e=1, jalr_e=1, result_src_e=10.
  - AUIPC -> alu_a_pc_e=1, alu_src_e=1, result_src_e=00.
- MUL (funct7=0000001), MULDIV_CYCLES=4:
  - stall_d=1 for 3 cycles after capture and muldiv_e held 4 cycles.
  - Then the next instruction loads.
  - stall_e pulsed mid-busy extends the hold by 1 cycle.
- flush_e during muldiv busy -> next cycle valid_e=0, stall_d=0; flush_e together with stall_e -> bubble wins.
- Illegal cases, each -> illegal_d=1, *_e control 0, illegal_sticky=1 and stays 1 until reset:
  - opcode=1111111
  - M-op with ENABLE_M=0
  - funct7=0100001

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Brief    : Shared opcodes, encodings and control bundle for RV32 decode.
// Revision : 1.0
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_M    = 7'b0000001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_src_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       alu_src;
        logic       alu_a_pc;
        logic       muldiv;
        res_src_t   result_src;
        logic [3:0] alu_control;
        logic [2:0] branch_control;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_pipe_alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Brief    : Maps opcode/funct fields to the 4-bit ALU operation code.
// Revision : 1.0
// ============================================================================
module alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [6:0] opcode,
    output logic [3:0] alu_control
);

    logic w_f3_addsub;
    logic w_f3_shr;

    assign w_f3_addsub = (funct3 == 3'b000);
    assign w_f3_shr    = (funct3 == 3'b101);

    // Code is {alt, funct3}; alt selects SUB (R only) or SRA (R and I).
    always_comb begin
        alu_control = ALU_ADD;
        case (opcode)
            OP_R:    alu_control = {funct7b5 & (w_f3_addsub | w_f3_shr), funct3};
            OP_I:    alu_control = {funct7b5 & w_f3_shr, funct3};
            OP_B:    alu_control = ALU_SUB;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Brief    : RV32 D-stage decode with registered D->E control and M-op stall.
// Revision : 1.0
// ============================================================================
module control_pipe
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_M      = 1'b1,
    parameter bit ENABLE_UPPER  = 1'b1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_d,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       stall_e,
    input  logic       flush_e,
    output logic       stall_d,
    output logic       illegal_d,
    output logic       illegal_sticky,
    output logic       valid_e,
    output logic       regwrite_e,
    output logic       memwrite_e,
    output logic       jump_e,
    output logic       jalr_e,
    output logic       branch_e,
    output logic       alu_src_e,
    output logic       alu_a_pc_e,
    output logic       muldiv_e,
    output logic [1:0] result_src_e,
    output logic [3:0] alu_control_e,
    output logic [2:0] branch_control_e
);

    localparam int                c_CNT_W    = $clog2(MULDIV_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MULDIV_CYCLES - 1);

    logic [3:0]         w_alu_code;
    ctrl_t              w_dec;
    logic               w_illegal;
    ctrl_t              r_ctrl;
    logic               r_valid;
    logic               r_sticky;
    logic [c_CNT_W-1:0] r_cnt;

    alu_decode u_alu_decode (
        .funct3      (funct3),
        .funct7b5    (funct7[5]),
        .opcode      (opcode),
        .alu_control (w_alu_code)
    );

    always_comb begin
        w_dec             = '0;
        w_illegal         = 1'b0;
        w_dec.alu_control = ALU_ADD;
        case (opcode)
            OP_LW: begin
                w_dec.regwrite   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = RES_MEM;
            end
            OP_SW: begin
                w_dec.alu_src  = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            OP_R: begin
                if (funct7 == FUNCT7_M) begin
                    if (ENABLE_M) begin
                        w_dec.regwrite    = 1'b1;
                        w_dec.muldiv      = 1'b1;
                        w_dec.alu_control = {1'b1, funct3};
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                    w_dec.regwrite    = 1'b1;
                    w_dec.alu_control = w_alu_code;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_I: begin
                w_dec.regwrite    = 1'b1;
                w_dec.alu_src     = 1'b1;
                w_dec.alu_control = w_alu_code;
            end
            OP_B: begin
                w_dec.branch         = 1'b1;
                w_dec.alu_control    = w_alu_code;
                w_dec.branch_control = funct3;
            end
            OP_JAL: begin
                w_dec.regwrite   = 1'b1;
                w_dec.result_src = RES_PC4;
                w_dec.jump       = 1'b1;
            end
            OP_JALR: begin
                w_dec.regwrite   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = RES_PC4;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_UPPER) begin
                    w_dec.regwrite   = 1'b1;
                    w_dec.result_src = RES_IMM;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (ENABLE_UPPER) begin
                    w_dec.regwrite = 1'b1;
                    w_dec.alu_src  = 1'b1;
                    w_dec.alu_a_pc = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_dec = '0;
        end
    end

    // Flush beats stall; an active M-op counter holds E until it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (flush_e) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else if (stall_e) begin
            r_cnt <= r_cnt;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end else begin
            r_valid <= valid_d;
            r_ctrl  <= valid_d ? w_dec : '0;
            if (valid_d && w_dec.muldiv) begin
                r_cnt <= c_CNT_LOAD;
            end
            if (valid_d && w_illegal) begin
                r_sticky <= 1'b1;
            end
        end
    end

    assign stall_d          = (r_cnt != '0);
    assign illegal_d        = valid_d & w_illegal;
    assign illegal_sticky   = r_sticky;
    assign valid_e          = r_valid;
    assign regwrite_e       = r_ctrl.regwrite;
    assign memwrite_e       = r_ctrl.memwrite;
    assign jump_e           = r_ctrl.jump;
    assign jalr_e           = r_ctrl.jalr;
    assign branch_e         = r_ctrl.branch;
    assign alu_src_e        = r_ctrl.alu_src;
    assign alu_a_pc_e       = r_ctrl.alu_a_pc;
    assign muldiv_e         = r_ctrl.muldiv;
    assign result_src_e     = r_ctrl.result_src;
    assign alu_control_e    = r_ctrl.alu_control;
    assign branch_control_e = r_ctrl.branch_control;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipe
// Brief    : Directed self-checking bench for control_pipe.
// Revision : 1.0
// ============================================================================
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall_e;
    logic       flush_e;

    logic       stall_d, illegal_d, illegal_sticky, valid_e, regwrite_e, memwrite_e;
    logic       jump_e, jalr_e, branch_e, alu_src_e, alu_a_pc_e, muldiv_e;
    logic [1:0] result_src_e;
    logic [3:0] alu_control_e;
    logic [2:0] branch_control_e;

    logic       stall_d2, illegal_d2, illegal_sticky2, valid_e2, regwrite_e2, memwrite_e2;
    logic       jump_e2, jalr_e2, branch_e2, alu_src_e2, alu_a_pc_e2, muldiv_e2;
    logic [1:0] result_src_e2;
    logic [3:0] alu_control_e2;
    logic [2:0] branch_control_e2;

    int total = 0;
    int bad   = 0;

    // {valid, regwrite, memwrite, jump, jalr, branch, alu_src, alu_a_pc, muldiv, res[1:0], alu[3:0], br[2:0]}
    logic [17:0] ctl;
    logic [17:0] ctl2;
    assign ctl  = {valid_e, regwrite_e, memwrite_e, jump_e, jalr_e, branch_e, alu_src_e,
                   alu_a_pc_e, muldiv_e, result_src_e, alu_control_e, branch_control_e};
    assign ctl2 = {valid_e2, regwrite_e2, memwrite_e2, jump_e2, jalr_e2, branch_e2, alu_src_e2,
                   alu_a_pc_e2, muldiv_e2, result_src_e2, alu_control_e2, branch_control_e2};

    localparam logic [17:0] c_ZERO    = 18'h00000;
    localparam logic [17:0] c_ILL     = {1'b1, 17'b0};
    localparam logic [17:0] c_LW      = {1'b1, 8'b1000_0100, 2'b01, 4'b0000, 3'b000};
    localparam logic [17:0] c_JALR    = {1'b1, 8'b1011_0100, 2'b10, 4'b0000, 3'b000};
    localparam logic [17:0] c_AUIPC   = {1'b1, 8'b1000_0110, 2'b00, 4'b0000, 3'b000};
    localparam logic [17:0] c_MUL     = {1'b1, 8'b1000_0001, 2'b00, 4'b1000, 3'b000};
    localparam logic [17:0] c_ADD     = {1'b1, 8'b1000_0000, 2'b00, 4'b0000, 3'b000};

    always #5 clk = ~clk;

    control_pipe dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d),
        .illegal_d(illegal_d), .illegal_sticky(illegal_sticky), .valid_e(valid_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .branch_e(branch_e), .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e),
        .muldiv_e(muldiv_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .branch_control_e(branch_control_e)
    );

    control_pipe #(.ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d2),
        .illegal_d(illegal_d2), .illegal_sticky(illegal_sticky2), .valid_e(valid_e2),
        .regwrite_e(regwrite_e2), .memwrite_e(memwrite_e2), .jump_e(jump_e2), .jalr_e(jalr_e2),
        .branch_e(branch_e2), .alu_src_e(alu_src_e2), .alu_a_pc_e(alu_a_pc_e2),
        .muldiv_e(muldiv_e2), .result_src_e(result_src_e2), .alu_control_e(alu_control_e2),
        .branch_control_e(branch_control_e2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        valid_d = v;
        opcode  = op;
        funct3  = f3;
        funct7  = f7;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        stall_e = 1'b0;
        flush_e = 1'b0;
        step();
        step();
        total++;
        if (ctl !== c_ZERO) begin
            $display("FAIL reset_ctl got=%h exp=%h", ctl, c_ZERO); bad++;
        end
        total++;
        if ({stall_d, illegal_sticky, illegal_d} !== 3'b000) begin
            $display("FAIL reset_flags got=%b exp=000", {stall_d, illegal_sticky, illegal_d}); bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (ctl !== c_ZERO) begin
            $display("FAIL idle_bubble got=%h exp=%h", ctl, c_ZERO); bad++;
        end
    endtask

    task automatic test_lw();
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        #1;
        total++;
        if (illegal_d !== 1'b0) begin
            $display("FAIL lw_illegal_d got=%b exp=0", illegal_d); bad++;
        end
        step();
        total++;
        if (ctl !== c_LW) begin
            $display("FAIL lw_ctl got=%h exp=%h", ctl, c_LW); bad++;
        end
    endtask

    task automatic test_jalr_auipc();
        drive(1'b1, 7'b1100111, 3'b000, 7'b0);
        step();
        total++;
        if (ctl !== c_JALR) begin
            $display("FAIL jalr_ctl got=%h exp=%h", ctl, c_JALR); bad++;
        end
        drive(1'b1, 7'b0010111, 3'b000, 7'b0);
        step();
        total++;
        if (ctl !== c_AUIPC) begin
            $display("FAIL auipc_ctl got=%h exp=%h", ctl, c_AUIPC); bad++;
        end
    endtask

    task automatic test_decode_table();
        logic [6:0]  op_t [8];
        logic [2:0]  f3_t [8];
        logic [6:0]  f7_t [8];
        logic [17:0] exp_t [8];
        op_t[0] = 7'b0100011; f3_t[0] = 3'b010; f7_t[0] = 7'b0000000;
        exp_t[0] = {1'b1, 8'b0100_0100, 2'b00, 4'b0000, 3'b000};
        op_t[1] = 7'b0110011; f3_t[1] = 3'b000; f7_t[1] = 7'b0100000;
        exp_t[1] = {1'b1, 8'b1000_0000, 2'b00, 4'b1000, 3'b000};
        op_t[2] = 7'b0010011; f3_t[2] = 3'b101; f7_t[2] = 7'b0100000;
        exp_t[2] = {1'b1, 8'b1000_0100, 2'b00, 4'b1101, 3'b000};
        op_t[3] = 7'b1100011; f3_t[3] = 3'b001; f7_t[3] = 7'b0000000;
        exp_t[3] = {1'b1, 8'b0000_1000, 2'b00, 4'b1000, 3'b001};
        op_t[4] = 7'b1101111; f3_t[4] = 3'b011; f7_t[4] = 7'b0000000;
        exp_t[4] = {1'b1, 8'b1010_0000, 2'b10, 4'b0000, 3'b000};
        op_t[5] = 7'b0110111; f3_t[5] = 3'b110; f7_t[5] = 7'b0000000;
        exp_t[5] = {1'b1, 8'b1000_0000, 2'b11, 4'b0000, 3'b000};
        op_t[6] = 7'b0110011; f3_t[6] = 3'b111; f7_t[6] = 7'b0000000;
        exp_t[6] = {1'b1, 8'b1000_0000, 2'b00, 4'b0111, 3'b000};
        op_t[7] = 7'b0010011; f3_t[7] = 3'b000; f7_t[7] = 7'b0100000;
        exp_t[7] = {1'b1, 8'b1000_0100, 2'b00, 4'b0000, 3'b000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, op_t[i], f3_t[i], f7_t[i]);
            step();
            total++;
            if (ctl !== exp_t[i]) begin
                $display("FAIL decode_%0d got=%h exp=%h", i, ctl, exp_t[i]); bad++;
            end
        end
    endtask

    task automatic test_muldiv();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        step();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ctl !== c_MUL || stall_d !== (k < 3)) begin
                $display("FAIL mul_hold_%0d got=%h/%b exp=%h/%b", k, ctl, stall_d, c_MUL, (k < 3));
                bad++;
            end
            step();
        end
        total++;
        if (ctl !== c_ADD || stall_d !== 1'b0) begin
            $display("FAIL mul_next got=%h/%b exp=%h/0", ctl, stall_d, c_ADD); bad++;
        end
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        step();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        step();
        stall_e = 1'b1;
        step();
        stall_e = 1'b0;
        total++;
        if (stall_d !== 1'b1 || ctl !== c_MUL) begin
            $display("FAIL mul_stall_e got=%h/%b exp=%h/1", ctl, stall_d, c_MUL); bad++;
        end
        step();
        total++;
        if (stall_d !== 1'b1 || ctl !== c_MUL) begin
            $display("FAIL mul_ext1 got=%h/%b exp=%h/1", ctl, stall_d, c_MUL); bad++;
        end
        step();
        total++;
        if (stall_d !== 1'b0 || ctl !== c_MUL) begin
            $display("FAIL mul_ext2 got=%h/%b exp=%h/0", ctl, stall_d, c_MUL); bad++;
        end
        step();
        total++;
        if (ctl !== c_ADD) begin
            $display("FAIL mul_ext_next got=%h exp=%h", ctl, c_ADD); bad++;
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        step();
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        step();
        flush_e = 1'b1;
        stall_e = 1'b1;
        step();
        flush_e = 1'b0;
        stall_e = 1'b0;
        total++;
        if (ctl !== c_ZERO || stall_d !== 1'b0) begin
            $display("FAIL flush_busy got=%h/%b exp=%h/0", ctl, stall_d, c_ZERO); bad++;
        end
        step();
        total++;
        if (ctl !== c_LW) begin
            $display("FAIL flush_resume got=%h exp=%h", ctl, c_LW); bad++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        step();
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== c_ZERO || stall_d !== 1'b0) begin
            $display("FAIL reset_mid got=%h/%b exp=%h/0", ctl, stall_d, c_ZERO); bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        #1;
        total++;
        if ({illegal_d2, illegal_d} !== 2'b10) begin
            $display("FAIL ill_m_comb got=%b exp=10", {illegal_d2, illegal_d}); bad++;
        end
        step();
        total++;
        if (ctl2 !== c_ILL || {illegal_sticky2, illegal_sticky} !== 2'b10) begin
            $display("FAIL ill_m_reg got=%h/%b exp=%h/10", ctl2, {illegal_sticky2, illegal_sticky}, c_ILL);
            bad++;
        end
        drive(1'b0, 7'b1111111, 3'b000, 7'b0);
        #1;
        total++;
        if (illegal_d !== 1'b0) begin
            $display("FAIL ill_novalid got=%b exp=0", illegal_d); bad++;
        end
        repeat (4) step();
        drive(1'b1, 7'b1111111, 3'b000, 7'b0);
        #1;
        total++;
        if (illegal_d !== 1'b1) begin
            $display("FAIL ill_op_comb got=%b exp=1", illegal_d); bad++;
        end
        step();
        total++;
        if (ctl !== c_ILL || illegal_sticky !== 1'b1) begin
            $display("FAIL ill_op_reg got=%h/%b exp=%h/1", ctl, illegal_sticky, c_ILL); bad++;
        end
        drive(1'b1, 7'b0110011, 3'b000, 7'b0100001);
        #1;
        total++;
        if (illegal_d !== 1'b1) begin
            $display("FAIL ill_f7_comb got=%b exp=1", illegal_d); bad++;
        end
        step();
        total++;
        if (ctl !== c_ILL) begin
            $display("FAIL ill_f7_reg got=%h exp=%h", ctl, c_ILL); bad++;
        end
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        step();
        total++;
        if (ctl !== c_LW || illegal_sticky !== 1'b1) begin
            $display("FAIL ill_sticky_hold got=%h/%b exp=%h/1", ctl, illegal_sticky, c_LW); bad++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({illegal_sticky2, illegal_sticky} !== 2'b00) begin
            $display("FAIL ill_sticky_clr got=%b exp=00", {illegal_sticky2, illegal_sticky}); bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_jalr_auipc();
        test_decode_table();
        test_muldiv();
        test_flush();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
